board_mem_arbiter: RTL

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

---
 rtl/board_mem_arbiter_pkg.sv | 18 +
 rtl/board_mem_arbiter_read_tag_pipe.sv | 39 +++
 rtl/board_mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/board_mem_arbiter_pkg.sv
// Shared types for the cell-board memory arbiter: requester IDs, FSM states
// and default board geometry.
package board_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 15;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic {
    REQ_RENDER = 1'b0,
    REQ_LOGIC  = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/board_mem_arbiter_read_tag_pipe.sv
// Read tag shift register: carries {valid, requester} alongside the BRAM read
// so returning data can be steered to the reader that issued it.
module read_tag_pipe
  import board_mem_arbiter_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    vld_in,
  input  req_id_e id_in,
  output logic    vld_out,
  output req_id_e id_out
);

  logic [STAGES-1:0] vld_q, vld_d;
  req_id_e           id_q [STAGES];
  req_id_e           id_d [STAGES];

  always_comb begin
    vld_d[0] = vld_in;
    id_d[0]  = id_in;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
    end
  end

  // Only the valid bits need reset; an invalid tag's ID is never looked at.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_q <= '0;
    else        vld_q <= vld_d;
    id_q <= id_d;
  end

  assign vld_out = vld_q[STAGES-1];
  assign id_out  = id_q[STAGES-1];

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port BRAM arbiter for the cell board: renderer reads, logic-engine
// reads/writes with starvation guard, and a full-board clear sweep.
module board_mem_arbiter
  import board_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH        = 2**ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  render_req_in,
  input  logic [ADDR_WIDTH-1:0] render_addr_in,
  output logic                  render_gnt_out,
  output logic                  render_rvalid_out,
  input  logic                  logic_rd_req_in,
  input  logic [ADDR_WIDTH-1:0] logic_rd_addr_in,
  output logic                  logic_rd_gnt_out,
  output logic                  logic_rvalid_out,
  input  logic                  logic_wr_req_in,
  input  logic [ADDR_WIDTH-1:0] logic_wr_addr_in,
  input  logic [DATA_WIDTH-1:0] logic_wr_data_in,
  output logic                  logic_wr_gnt_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  input  logic                  clear_start_in,
  output logic                  clear_busy_out,
  output logic                  clear_done_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_we_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  arb_state_e            state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  rr_wr_q, rr_wr_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clear_done_q, clear_done_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic    logic_pend, starved, pick_wr, logic_gnt;
  logic    tag_vld;
  req_id_e tag_id;

  assign logic_pend = logic_rd_req_in | logic_wr_req_in;
  assign starved    = (starve_q == STARVE_MAX) && logic_pend;
  assign pick_wr    = logic_wr_req_in && (!logic_rd_req_in || rr_wr_q);
  assign logic_gnt  = logic_rd_gnt_out | logic_wr_gnt_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_ARB;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (clear_start_in) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  // Grants are combinational so a request is accepted in the cycle it is seen.
  always_comb begin
    render_gnt_out   = 1'b0;
    logic_rd_gnt_out = 1'b0;
    logic_wr_gnt_out = 1'b0;
    clear_busy_out   = (state_q == ST_CLEAR);
    if (state_q == ST_ARB && !rst_in) begin
      if (render_req_in && !starved) begin
        render_gnt_out = 1'b1;
      end else if (logic_pend) begin
        logic_wr_gnt_out = pick_wr;
        logic_rd_gnt_out = !pick_wr;
      end
    end
  end

  always_comb begin
    starve_d     = starve_q;
    rr_wr_d      = logic_gnt ? !rr_wr_q : rr_wr_q;
    clr_addr_d   = '0;
    clear_done_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d   = clr_addr_q + ADDR_WIDTH'(1);
      clear_done_d = (clr_addr_q == LAST_ADDR);
      mem_addr_d   = clr_addr_q;
      mem_we_d     = 1'b1;
      mem_wdata_d  = '0;
    end else begin
      if (logic_gnt || !logic_pend) starve_d = '0;
      else if (render_gnt_out)      starve_d = sat_inc(starve_q);
      if (render_gnt_out) begin
        mem_addr_d = render_addr_in;
      end else if (logic_rd_gnt_out) begin
        mem_addr_d = logic_rd_addr_in;
      end else if (logic_wr_gnt_out) begin
        mem_addr_d  = logic_wr_addr_in;
        mem_wdata_d = logic_wr_data_in;
        mem_we_d    = 1'b1;
      end
    end
  end

  // Issue stage: accepted transaction presented to the BRAM port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_q     <= '0;
      rr_wr_q      <= 1'b0;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      rr_wr_q      <= rr_wr_d;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_addr_out   = mem_addr_q;
  assign mem_we_out     = mem_we_q;
  assign mem_wdata_out  = mem_wdata_q;
  assign clear_done_out = clear_done_q;

  // Return stage: tag emerges in the cycle the BRAM data arrives.
  read_tag_pipe #(.STAGES(RD_LATENCY + 1)) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .vld_in  (render_gnt_out | logic_rd_gnt_out),
    .id_in   (logic_rd_gnt_out ? REQ_LOGIC : REQ_RENDER),
    .vld_out (tag_vld),
    .id_out  (tag_id)
  );

  assign render_rvalid_out = tag_vld && (tag_id == REQ_RENDER);
  assign logic_rvalid_out  = tag_vld && (tag_id == REQ_LOGIC);
  assign rdata_out         = mem_rdata_in;

endmodule
